// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined RV32M multiplier: op codes,
// default geometry and the per-stage payload carried down the pipe.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  localparam int MUL_STAGES = 4;
  localparam int MUL_TAG_W  = 5;

  // Payload registered at the end of every stage. b_rem holds the
  // multiplier bits not yet consumed, LSB-first.
  typedef struct packed {
    logic                 valid;
    mul_op_e              op;
    logic                 neg;
    logic [MUL_TAG_W-1:0] tag;
    logic [31:0]          a_mag;
    logic [31:0]          b_rem;
    logic [63:0]          acc;
  } mul_stage_t;

  // Two's-complement magnitude; 0x80000000 maps to 2^31 unchanged.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    if (sgn) begin
      return (~v) + 32'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/mul_stage.sv
// One multiplier pipeline stage: folds BITS multiplier bits into the
// 64-bit accumulator and registers the payload under stall/reset control.
module mul_stage
  import mul_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  mul_stage_t i_d,
  output mul_stage_t o_q
);

  logic [BITS-1:0] w_chunk;
  logic [63:0]     w_prod;
  mul_stage_t      w_next;
  mul_stage_t      r_q;

  // Partial product for this stage's slice of the multiplier.
  always_comb begin
    w_chunk      = i_d.b_rem[BITS-1:0];
    w_prod       = 64'(i_d.a_mag) * 64'(w_chunk);
    w_next       = i_d;
    w_next.acc   = i_d.acc + (w_prod << SHIFT);
    w_next.b_rem = i_d.b_rem >> BITS;
  end

  // Stage register: reset clears everything, stall freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (!stall) begin
      r_q <= w_next;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mul_unsigned_signed_pipelined.sv
// Pipelined 32x32 multiplier for MUL/MULH/MULHSU/MULHU. Operands are
// converted to magnitudes up front, multiplied unsigned over STAGES
// stages, and the sign is reapplied on the final accumulator.
module mul_unsigned_signed_pipelined
  import mul_pkg::*;
#(
  parameter int STAGES = MUL_STAGES,
  parameter int TAG_W  = MUL_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_result
);

  localparam int BITS = 32 / STAGES;

  logic       w_a_sgn;
  logic       w_b_sgn;
  logic [63:0] w_p;
  mul_stage_t w_stage [0:STAGES];
  mul_stage_t w_last;
  logic       w_unused;

  // Input conditioning: decide operand signedness and build stage-0 payload.
  always_comb begin
    case (mul_op_e'(i_op))
      MUL_OP_MULH: begin
        w_a_sgn = i_rs1[31];
        w_b_sgn = i_rs2[31];
      end
      MUL_OP_MULHSU: begin
        w_a_sgn = i_rs1[31];
        w_b_sgn = 1'b0;
      end
      default: begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
      end
    endcase
    w_stage[0].valid = i_valid;
    w_stage[0].op    = mul_op_e'(i_op);
    w_stage[0].neg   = w_a_sgn ^ w_b_sgn;
    w_stage[0].tag   = MUL_TAG_W'(i_tag);
    w_stage[0].a_mag = mag32(i_rs1, w_a_sgn);
    w_stage[0].b_rem = mag32(i_rs2, w_b_sgn);
    w_stage[0].acc   = 64'd0;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    mul_stage #(
      .BITS  (BITS),
      .SHIFT (g * BITS)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .i_d   (w_stage[g]),
      .o_q   (w_stage[g+1])
    );
  end

  assign w_last = w_stage[STAGES];

  // Output: reapply the sign and pick the requested product half.
  always_comb begin
    if (w_last.neg) begin
      w_p = 64'd0 - w_last.acc;
    end else begin
      w_p = w_last.acc;
    end
    case (w_last.op)
      MUL_OP_MUL: o_result = w_p[31:0];
      default:    o_result = w_p[63:32];
    endcase
    o_valid = w_last.valid;
    o_tag   = TAG_W'(w_last.tag);
  end

  // Operand fields are fully consumed by the last stage.
  assign w_unused = ^{w_last.a_mag, w_last.b_rem, w_last.tag};

endmodule

// File: tb/tb_mul_unsigned_signed_pipelined.sv
// Self-checking bench: a queue-based timing/result model predicts every
// output cycle; directed cases pin both the model and the DUT.
module tb_mul_unsigned_signed_pipelined;

  localparam int STAGES = 4;
  localparam int TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             i_valid;
  logic [1:0]       i_op;
  logic [31:0]      i_rs1;
  logic [31:0]      i_rs2;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic [TAG_W-1:0] o_tag;
  logic [31:0]      o_result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    int               age;
  } ent_t;
  ent_t q[$];

  mul_unsigned_signed_pipelined #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .i_valid(i_valid), .i_op(i_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_tag(i_tag),
    .o_valid(o_valid), .o_tag(o_tag), .o_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact 64-bit product from signed/unsigned interpretations.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     ua = longint'({32'd0, a});
    longint     ub = longint'({32'd0, b});
    logic [63:0] p;
    case (op)
      2'd0:    p = 64'(ua * ub);
      2'd1:    p = 64'(sa * sb);
      2'd2:    p = 64'(sa * ub);
      default: p = {32'd0, a} * {32'd0, b};
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Compare process: check outputs against the model, then advance the
  // model by the inputs that the next rising edge will see.
  always @(negedge clk) begin
    logic exp_v;
    exp_v = (q.size() > 0) && (q[0].age == STAGES);
    chk("o_valid", {63'd0, o_valid}, {63'd0, exp_v});
    if (exp_v && o_valid) begin
      chk("o_tag", {59'd0, o_tag}, {59'd0, q[0].tag});
      chk("o_result", {32'd0, o_result}, {32'd0, q[0].res});
    end
    if (rst) begin
      q.delete();
    end else if (!stall) begin
      if (exp_v) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (i_valid) q.push_back('{tag: i_tag, res: ref_mul(i_op, i_rs1, i_rs2), age: 1});
    end
  end

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] t, input logic s);
    i_valid = v; i_op = op; i_rs1 = a; i_rs2 = b; i_tag = t; stall = s;
  endtask

  // Issue one op into an idle pipe; check latency, pulse width and value.
  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] t, input logic [31:0] exp);
    int seen;
    seen = 0;
    @(posedge clk); #1;
    drive(1'b1, op, a, b, t, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b0);
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(negedge clk);
      if (o_valid) begin
        seen = c;
        chk({name, "_res"}, {32'd0, o_result}, {32'd0, exp});
        chk({name, "_tag"}, {59'd0, o_tag}, {59'd0, t});
      end
    end
    chk({name, "_latency"}, 64'(seen), 64'(STAGES));
    @(negedge clk);
    chk({name, "_pulse"}, {63'd0, o_valid}, 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int seen;
    int accepted;
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_tag", {59'd0, o_tag}, 64'd0);
    chk("reset_result", {32'd0, o_result}, 64'd0);
    rst = 1'b0;

    // Model pins
    chk("model_mul", {32'd0, ref_mul(2'd0, 32'd7, 32'hFFFF_FFFD)}, 64'hFFFF_FFEB);
    chk("model_mulh", {32'd0, ref_mul(2'd1, 32'h8000_0000, 32'h8000_0000)}, 64'h4000_0000);
    chk("model_mulhu", {32'd0, ref_mul(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFE);
    chk("model_mulhsu", {32'd0, ref_mul(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFF);

    directed("mul7", 2'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
    directed("mulh_min", 2'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000);
    directed("mulhu_max", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE);
    directed("mulhsu_m1", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF);
    directed("mul_m1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0000_0001);
    directed("mulh_zero", 2'd1, 32'd0, 32'hFFFF_FFFF, 5'd13, 32'd0);

    // Four back-to-back ops with a 3-cycle stall from cycle 2.
    @(posedge clk); #1;
    drive(1'b1, 2'd0, 32'd11, 32'd13, 5'd1, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 2'd1, 32'hFFFF_FFF0, 32'd5, 5'd2, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 2'd2, 32'h8000_0001, 32'hF000_0000, 5'd3, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd4, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b0);
    // tag 1 accepted 6 edges earlier; its first o_valid is cycle 7
    seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      if (o_valid && o_tag == 5'd1) seen = c;
      @(posedge clk); #1;
    end
    chk("stall_latency", 64'(seen), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_drained", 64'(q.size()), 64'd0);

    // Reset mid-operation.
    drive(1'b1, 2'd0, 32'd3, 32'd4, 5'd7, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stall = 1'b0;
    for (int c = 0; c < 11; c++) begin
      chk("flush_valid", {63'd0, o_valid}, 64'd0);
      @(posedge clk); #1;
    end
    directed("after_reset", 2'd1, 32'hFFFF_FFFE, 32'd3, 5'd21, 32'hFFFF_FFFF);

    // Random sweep with bubbles and stalls.
    accepted = 0;
    while (accepted < 1000) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(),
            TAG_W'($urandom()), $urandom_range(0, 5) == 0);
      if (i_valid && !stall) accepted++;
    end
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b0);
    for (int c = 0; c < 50 && q.size() > 0; c++) begin
      @(posedge clk); #1;
    end
    chk("random_drain", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
